cmd_response_receiver: RTL and testbench
========================================

# cmd_response_receiver

Serial-to-parallel receiver for the SD CMD line: it captures the card's response frame and hands it to the command layer. It sits directly downstream of the CMD pad, alongside the parallel-to-serial command transmitter. Once the CMD control FSM has sent a command, it arms this block. The block waits a bounded number of cycles for the start bit, shifts in an N-bit frame MSB-first, checks the end bit and CRC7, and pulses `complete` with the frame on `parallel`.

## Interface
Parameters:
- `N`, 48: response frame length in bits (48 for R1/R3/R6/R7, 136 for R2).
- `CRC_SKIP`, 0: leading frame bits excluded from the CRC (0 for 48-bit frames, 8 for R2).
- `TIMEOUT`, 64: max cycles spent in WAIT_START (NCR limit).

Ports (reset `reset`, synchronous, active-high; clock `sd_clock`):
- `sd_clock`  in  1  sampling clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  arm request from the CMD control FSM; rising edge arms, low aborts.
- `serial`  in  1  CMD line from pad; idles high.
- `parallel`  out  N  last received frame; bit N-1 is the start bit.
- `complete`  out  1  one-cycle pulse when a frame is captured.
- `timeout`  out  1  one-cycle pulse when no start bit arrives within TIMEOUT cycles.
- `crc_error`  out  1  CRC7 mismatch on the last frame.
- `end_error`  out  1  end bit (bit 0) was 0 on the last frame.
- `busy`  out  1  high in WAIT_START and RECEIVE.

## Operation
- Reset: state IDLE; `parallel`=0; `complete`, `timeout`, `crc_error`, `end_error`, `busy`=0; shift register, bit counter, timer, CRC and edge-detect register all 0.
- Arm condition: `enable`=1 this cycle and `enable`=0 in the previous cycle.
- IDLE: on the arm condition go to WAIT_START with timer=0. A level-high `enable` alone never re-arms.
- WAIT_START:
  - Each posedge samples `serial`. If `serial`=0, the start bit is taken: shift it in, set count=1, clear the CRC, clear `crc_error` and `end_error`, go to RECEIVE.
  - Else, if timer=TIMEOUT-1, go to IDLE and pulse `timeout`. Otherwise timer+1.
  - Start bit has priority over timeout on the same sample.
- RECEIVE:
  - Shift `serial` in, MSB-first, each cycle; count+1.
  - On the sample with count=N-1 (end bit), go to DONE.
- DONE (one cycle):
  - `parallel` is loaded with the assembled frame.
  - `complete`=1; `end_error` is set to the inverse of the end bit; `crc_error` is the CRC result.
  - Next state is IDLE.
- Abort: `enable`=0 in WAIT_START or RECEIVE returns the block to IDLE next cycle. There is no pulse, and `parallel` and the error flags are unchanged.
- `parallel`, `crc_error` and `end_error` hold until the next DONE. The error flags are also cleared at the next start bit.
- CRC7:
  - Polynomial x^7+x^3+1, register initialised to 0.
  - Updated serially with frame bits N-1-CRC_SKIP down to 8, including the start bit when CRC_SKIP=0.
  - Compared against frame bits [7:1].
- Counter widths: the bit counter is $clog2(N) bits and the timer is $clog2(TIMEOUT) bits. There is no wrap inside a frame.

## Timing
- Start bit sampled at posedge k: data bits are sampled at k+1 … k+N-1, and `complete`, `parallel` and the error flags are valid at cycle k+N, with `complete` high for exactly one cycle.
- `busy` rises the cycle after the arm edge and falls in the DONE or timeout cycle.
- Timeout: armed at cycle a, with `serial` held high, `timeout` pulses at cycle a+TIMEOUT+1.
- Re-arm: a new arm edge is accepted in the cycle after DONE.
- Reset mid-frame: outputs return to reset values on the next posedge and no partial frame is ever presented.

## Configuration
- `CMD_RX_CRC7_EN` defined: the CRC7 engine and comparison are built, and `crc_error` behaves as above.
- Undefined: no CRC logic is built, `crc_error` is tied to 0, and all other behaviour and timing are unchanged.

## Test plan
- Reset, then arm and drive 48'h40_0000_0000_95 two cycles after the arm edge -> `parallel`=48'h400000000095, a single `complete` pulse, `crc_error`=0, `end_error`=0.
- Drive 48'h11_0000_0900_67 -> `parallel`=48'h110000090067, `crc_error`=0. Repeat with the CRC byte 8'h65 -> `crc_error`=1 (0 when built without `CMD_RX_CRC7_EN`).
- Arm, then hold `serial`=1 (TIMEOUT=64) -> `timeout` pulses exactly 65 cycles after the arm edge, `complete` never asserts, `parallel` is unchanged.
- Frame 48'h40_0000_0000_94 (end bit 0) -> `end_error`=1, `complete` pulses.
- Drop `enable` at bit 20, then assert `reset` mid-frame on a second attempt -> no `complete`. After the abort, `parallel` holds its previous value and `busy`=0; after the reset, all outputs are 0.
- N=136, CRC_SKIP=8: drive a valid R2 frame -> all 136 bits are captured, with `complete` at k+136 and `crc_error`=0.

Source files
------------

// File: rtl/cmd_response_receiver.sv
// SD CMD-line response receiver: waits for a start bit, shifts in an N-bit frame MSB-first,
// and flags end-bit and CRC7 errors. The CRC7 engine is built only when CMD_RX_CRC7_EN is defined.
module cmd_response_receiver #(
  parameter int N        = 48,
  parameter int CRC_SKIP = 0,
  parameter int TIMEOUT  = 64
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         serial,
  output logic [N-1:0] parallel,
  output logic         complete,
  output logic         timeout,
  output logic         crc_error,
  output logic         end_error,
  output logic         busy
);
  localparam int CW = $clog2(N);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(N - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_RECEIVE    = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_shift, w_shift_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [N-1:0]  r_parallel, w_parallel_nxt;
  logic          r_enable_d;
  logic          r_complete, w_complete_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic          r_crc_error, w_crc_error_nxt;
  logic          r_end_error, w_end_error_nxt;
  logic          r_busy, w_busy_nxt;
  logic          w_arm;
  logic          w_crc_mismatch;

  assign w_arm = enable & ~r_enable_d;

`ifdef CMD_RX_CRC7_EN
  logic [6:0] r_crc, w_crc_nxt;
  logic       w_crc_window;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = crc[6] ^ bit_in;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // r_count is the number of bits already received, i.e. frame bit N-1-r_count is on the line
  assign w_crc_window   = (int'(r_count) >= CRC_SKIP) && (int'(r_count) <= N - 9);
  assign w_crc_mismatch = (r_crc != r_shift[6:0]);

  // CRC next value; a zero start bit entering a cleared register leaves it zero
  always_comb begin
    w_crc_nxt = r_crc;
    if ((r_state == S_WAIT_START) && !serial) begin
      w_crc_nxt = 7'd0;
    end else if ((r_state == S_RECEIVE) && w_crc_window) begin
      w_crc_nxt = crc7_step(r_crc, serial);
    end else begin
      w_crc_nxt = r_crc;
    end
  end

  // CRC register
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      r_crc <= 7'd0;
    end else begin
      r_crc <= w_crc_nxt;
    end
  end
`else
  assign w_crc_mismatch = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_count_nxt     = r_count;
    w_timer_nxt     = r_timer;
    w_parallel_nxt  = r_parallel;
    w_complete_nxt  = 1'b0;
    w_timeout_nxt   = 1'b0;
    w_crc_error_nxt = r_crc_error;
    w_end_error_nxt = r_end_error;
    case (r_state)
      S_IDLE: begin
        if (w_arm) begin
          w_state_nxt = S_WAIT_START;
          w_timer_nxt = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_START: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (!serial) begin
          w_state_nxt     = S_RECEIVE;
          w_shift_nxt     = {{(N-1){1'b0}}, serial};
          w_count_nxt     = CW'(1);
          w_crc_error_nxt = 1'b0;
          w_end_error_nxt = 1'b0;
        end else if (r_timer == TIMER_MAX) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_RECEIVE: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_shift_nxt = {r_shift[N-2:0], serial};
          w_count_nxt = r_count + CW'(1);
          // The end-bit sample loads the outputs so they are valid throughout DONE
          if (r_count == LAST_BIT) begin
            w_state_nxt     = S_DONE;
            w_parallel_nxt  = {r_shift[N-2:0], serial};
            w_complete_nxt  = 1'b1;
            w_end_error_nxt = ~serial;
            w_crc_error_nxt = w_crc_mismatch;
          end else begin
            w_state_nxt = S_RECEIVE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt == S_WAIT_START) || (w_state_nxt == S_RECEIVE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_count     <= '0;
      r_timer     <= '0;
      r_parallel  <= '0;
      r_enable_d  <= 1'b0;
      r_complete  <= 1'b0;
      r_timeout   <= 1'b0;
      r_crc_error <= 1'b0;
      r_end_error <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_count     <= w_count_nxt;
      r_timer     <= w_timer_nxt;
      r_parallel  <= w_parallel_nxt;
      r_enable_d  <= enable;
      r_complete  <= w_complete_nxt;
      r_timeout   <= w_timeout_nxt;
      r_crc_error <= w_crc_error_nxt;
      r_end_error <= w_end_error_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign parallel  = r_parallel;
  assign complete  = r_complete;
  assign timeout   = r_timeout;
  assign crc_error = r_crc_error;
  assign end_error = r_end_error;
  assign busy      = r_busy;
endmodule

// File: tb/tb_cmd_response_receiver.sv
// Directed bench for cmd_response_receiver: a 48-bit instance and a 136-bit R2 instance.
module tb_cmd_response_receiver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CMD_RX_CRC7_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  logic         reset, enable, serial, en2, ser2;
  logic [47:0]  par;
  logic         comp, tout, crce, ende, busy;
  logic [135:0] par2;
  logic         comp2, tout2, crce2, ende2, busy2;

  int checks = 0;
  int errors = 0;
  int n_comp = 0, n_tout = 0, n_comp2 = 0;
  int cnt, base_c, base_t;
  logic [47:0]  par_hold;
  logic [119:0] cid;
  logic [135:0] f2;

  cmd_response_receiver u_dut (
    .sd_clock(clk), .reset(reset), .enable(enable), .serial(serial),
    .parallel(par), .complete(comp), .timeout(tout),
    .crc_error(crce), .end_error(ende), .busy(busy)
  );

  cmd_response_receiver #(.N(136), .CRC_SKIP(8), .TIMEOUT(64)) u_dut_r2 (
    .sd_clock(clk), .reset(reset), .enable(en2), .serial(ser2),
    .parallel(par2), .complete(comp2), .timeout(tout2),
    .crc_error(crce2), .end_error(ende2), .busy(busy2)
  );

  // Pulse counters: each posedge counts the value held during the preceding cycle
  always @(posedge clk) begin
    n_comp  <= n_comp + (comp ? 1 : 0);
    n_tout  <= n_tout + (tout ? 1 : 0);
    n_comp2 <= n_comp2 + (comp2 ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r2, input logic v);
    if (r2) ser2 = v;
    else serial = v;
  endtask

  // Returns at the negedge following the arm edge
  task automatic arm(input bit r2);
    if (r2) en2 = 1'b0;
    else enable = 1'b0;
    @(negedge clk);
    if (r2) en2 = 1'b1;
    else enable = 1'b1;
    @(negedge clk);
    chk("busy after arm", r2 ? busy2 : busy, 1'b1);
  endtask

  // Start bit is sampled idle+1 edges after the arm edge
  task automatic send_frame(input logic [135:0] f, input int nbits, input int idle, input bit r2,
                            input logic exp_crc, input logic exp_end);
    int base;
    base = r2 ? n_comp2 : n_comp;
    drive(r2, 1'b1);
    repeat (idle) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      drive(r2, f[i]);
      @(negedge clk);
      if (i == nbits - 1) chk("flags cleared at start bit", r2 ? {crce2, ende2} : {crce, ende}, 2'b00);
      if (i == 1) chk("no complete before end bit", r2 ? comp2 : comp, 1'b0);
    end
    drive(r2, 1'b1);
    chk("complete at k+N", r2 ? comp2 : comp, 1'b1);
    chk("parallel", r2 ? par2 : {88'd0, par}, f);
    chk("crc_error", r2 ? crce2 : crce, exp_crc);
    chk("end_error", r2 ? ende2 : ende, exp_end);
    chk("busy low in DONE", r2 ? busy2 : busy, 1'b0);
    @(negedge clk);
    chk("complete one cycle", r2 ? comp2 : comp, 1'b0);
    chk("one complete per frame", (r2 ? n_comp2 : n_comp) - base, 1);
  endtask

  function automatic logic [6:0] crc7_ref(input logic [119:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 119; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b0; serial = 1'b1; en2 = 1'b0; ser2 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset parallel", par, 48'd0);
    chk("reset flags", {comp, tout, crce, ende, busy}, 5'd0);
    chk("reset r2 parallel", par2, 136'd0);

    // Valid CMD0-style frame, start bit two edges after the arm edge
    arm(1'b0);
    send_frame(136'h40_0000_0000_95, 48, 1, 1'b0, 1'b0, 1'b0);

    // Holding enable high must not re-arm
    base_c = n_comp;
    serial = 1'b0;
    repeat (3) @(negedge clk);
    chk("level enable does not re-arm", busy, 1'b0);
    serial = 1'b1;
    @(negedge clk);
    chk("no complete from level enable", n_comp - base_c, 0);

    arm(1'b0);
    send_frame(136'h11_0000_0900_67, 48, 1, 1'b0, 1'b0, 1'b0);
    arm(1'b0);
    send_frame(136'h11_0000_0900_65, 48, 1, 1'b0, CRC_ON, 1'b0);
    arm(1'b0);
    send_frame(136'h40_0000_0000_94, 48, 1, 1'b0, 1'b0, 1'b1);

    // Abort in WAIT_START keeps parallel and flags
    arm(1'b0);
    repeat (5) @(negedge clk);
    base_c = n_comp; base_t = n_tout;
    enable = 1'b0;
    @(negedge clk);
    chk("abort wait busy", busy, 1'b0);
    repeat (70) @(negedge clk);
    chk("abort wait no timeout", n_tout - base_t, 0);
    chk("abort wait no complete", n_comp - base_c, 0);
    chk("abort wait parallel held", par, 48'h40_0000_0000_94);
    chk("abort wait end_error held", ende, 1'b1);

    // Timeout: first seen after edge a+64, i.e. presented to edge a+65
    arm(1'b0);
    base_c = n_comp; base_t = n_tout;
    cnt = 0;
    while (tout !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout latency", cnt, 64);
    chk("busy low with timeout", busy, 1'b0);
    @(negedge clk);
    chk("timeout one cycle", tout, 1'b0);
    chk("one timeout pulse", n_tout - base_t, 1);
    chk("no complete on timeout", n_comp - base_c, 0);
    chk("timeout parallel held", par, 48'h40_0000_0000_94);

    // Start bit on the last timer sample wins over timeout
    base_t = n_tout;
    arm(1'b0);
    send_frame(136'h40_0000_0000_95, 48, 63, 1'b0, 1'b0, 1'b0);
    chk("start beats timeout", n_tout - base_t, 0);

    // Abort at bit 20 of a frame
    arm(1'b0);
    base_c = n_comp;
    par_hold = 48'h11_0000_0900_67;
    serial = 1'b1;
    @(negedge clk);
    for (int i = 47; i >= 28; i--) begin
      serial = par_hold[i];
      @(negedge clk);
    end
    chk("busy while receiving", busy, 1'b1);
    enable = 1'b0;
    serial = par_hold[27];
    @(negedge clk);
    chk("abort rx busy", busy, 1'b0);
    serial = 1'b1;
    repeat (60) @(negedge clk);
    chk("abort rx no complete", n_comp - base_c, 0);
    chk("abort rx parallel held", par, 48'h40_0000_0000_95);

    // Reset mid-frame
    arm(1'b0);
    base_c = n_comp;
    par_hold = 48'h40_0000_0000_94;
    serial = 1'b1;
    @(negedge clk);
    for (int i = 47; i >= 38; i--) begin
      serial = par_hold[i];
      @(negedge clk);
    end
    reset = 1'b1; enable = 1'b0; serial = 1'b1;
    @(negedge clk);
    chk("mid reset parallel", par, 48'd0);
    chk("mid reset flags", {comp, tout, crce, ende, busy}, 5'd0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("no partial frame", n_comp - base_c, 0);
    arm(1'b0);
    send_frame(136'h40_0000_0000_94, 48, 1, 1'b0, 1'b0, 1'b1);

    // R2 frame: header 0x3F excluded from CRC
    cid = 120'h03_5344_5344_3136_4780_1234_5678_0100;
    f2  = {8'h3F, cid, crc7_ref(cid), 1'b1};
    arm(1'b1);
    send_frame(f2, 136, 1, 1'b1, 1'b0, 1'b0);
    f2[1] = ~f2[1];
    arm(1'b1);
    send_frame(f2, 136, 1, 1'b1, CRC_ON, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
